id_ex_decode: RTL and testbench
===============================

Name: id_ex_decode

Overview:
- Decode stage and ID/EX pipeline register for the RV32I pipeline; produces the ALU-side interface of the execute stage.
- Takes the fetched instruction, PC and register-file read data, and decodes the ALU op, operand 1, operand 2 (immediate generation included), memory and writeback controls.
- Registers all results once per clock, with stall (hold) and flush (bubble) control from the hazard unit.

Parameters:
- XLEN, 32, datapath width (fixed at 32 for RV32I).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset (one clock; reset is synchronous and active-high)
- stall_i  in  1  hold ID/EX contents
- flush_i  in  1  load bubble
- valid_i  in  1  instr_i is valid
- pc_i  in  32  instruction PC
- instr_i  in  32  instruction word
- rs1_data_i  in  32  register file rs1 value
- rs2_data_i  in  32  register file rs2 value
- valid_o  out  1  ID/EX entry valid
- pc_o  out  32  registered PC
- alu_op_o  out  4  ALU operation
- operand1_o  out  32  ALU operand 1
- operand2_o  out  32  ALU operand 2
- rs1_data_o  out  32  rs1 value (branch compare)
- rs2_data_o  out  32  rs2 value (branch compare / store data)
- rd_addr_o  out  5  destination register
- rd_wen_o  out  1  register write enable
- mem_rd_o  out  1  load
- mem_wr_o  out  1  store
- funct3_o  out  3  access size / branch condition
- branch_o  out  1  conditional branch
- jump_o  out  1  JAL/JALR
- wb_sel_o  out  2  writeback source: 0 ALU, 1 MEM, 2 PC+4
- illegal_o  out  1  unsupported encoding

Behaviour:
- ALU op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, LUI 10.
- Decode is combinational from the inputs; all outputs are registered with latency 1 cycle.
- Register update priority: rst_i > flush_i > stall_i > load.
- Reset and flush: every output is 0.
- Stall: every output holds its value. Flush and stall asserted in the same cycle: flush wins.
- valid_i=0 loads a bubble, identical to flush.
- Immediates are sign-extended from bit 31:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - U: {instr[31:12], 12'd0}
- Opcode decode:
  - OP 0110011: op1=rs1, op2=rs2. funct3 000 gives ADD, or SUB if funct7[5]. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA (funct7[5]), 110 OR, 111 AND. funct7 must be 0000000, or 0100000 only with funct3 000/101; anything else is illegal.
  - OP-IMM 0010011: same mapping, op2=I-imm. funct3 000 is always ADD. Shifts need funct7 0000000, or 0100000 for SRAI; anything else is illegal.
  - LUI 0110111: op LUI, op1=0, op2=U-imm.
  - AUIPC 0010111: ADD, op1=pc, op2=U-imm.
  - LOAD 0000011: ADD rs1+I-imm, mem_rd_o=1, wb_sel 1. funct3 must be in {000,001,010,100,101}.
  - STORE 0100011: ADD rs1+S-imm, mem_wr_o=1, rd_wen_o=0. funct3 must be in {000,001,010}.
  - BRANCH 1100011: ADD pc+B-imm, branch_o=1, rd_wen_o=0. funct3 010/011 are illegal.
  - JAL 1101111: ADD pc+J-imm, jump_o=1, wb_sel 2.
  - JALR 1100111: ADD rs1+I-imm, jump_o=1, wb_sel 2. funct3 must be 000.
- rd_wen_o=1 only for OP, OP-IMM, LUI, AUIPC, LOAD, JAL and JALR, and only when rd≠0.
- Illegal instruction: valid_o=1, illegal_o=1; rd_wen_o, mem_rd_o, mem_wr_o, branch_o and jump_o are all 0.
- funct3_o, rd_addr_o, pc_o, rs1_data_o and rs2_data_o pass through for every valid instruction.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle valid_o=1, alu_op 0, op1=5, op2=7, rd_addr 3, rd_wen 1, wb_sel 0.
- sub x3,x1,x2 (0x402081B3) -> alu_op 1. srai x5,x6,3 (0x40335293) -> alu_op 7, op2=0x00000403, rd_wen 1.
- lui x1,0xABCDE (0xABCDE0B7) -> alu_op 10, op1=0, op2=0xABCDE000. add x0,x1,x2 (0x00208033) -> rd_wen 0.
- sw x2,-4(x1) (0xFE20AE23), rs1=0x100, rs2=0x55 -> alu_op 0, op1=0x100, op2=0xFFFFFFFC, mem_wr 1, rd_wen 0, rs2_data_o=0x55, funct3 2.
- Load add, then stall_i=1 for 3 cycles with instr_i changed -> outputs unchanged. Then flush_i=stall_i=1 -> valid_o=0, rd_wen 0, mem_wr 0. Then rst_i mid-stream -> all outputs 0 next cycle.
- instr 0x00000000 with valid_i=1 -> illegal_o=1, valid_o=1, all write and memory enables 0. Same instr with valid_i=0 -> bubble, illegal_o=0.

Source files
------------

// File: rtl/id_ex_decode.sv
// id_ex_decode: RV32I decode stage and ID/EX pipeline register.
//
// Decodes the instruction combinationally. It produces the ALU operation,
// both ALU operands (immediate generation included), memory controls and
// writeback controls. The whole decoded bundle is registered once per clock.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   stall_i, flush_i      hazard control: hold the entry, or load a bubble
//   valid_i               instr_i is valid; when low, a bubble is loaded
//   pc_i, instr_i         fetched PC and instruction word
//   rs1_data_i/rs2_data_i register file read data
//   valid_o .. illegal_o  registered ID/EX entry for the execute stage
//
// Register priority: reset > flush > stall > load.

module id_ex_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] operand1_o,
  output logic [XLEN-1:0] operand2_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o,
  output logic            mem_rd_o,
  output logic            mem_wr_o,
  output logic [2:0]      funct3_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic [1:0]      wb_sel_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            rd_wen;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      funct3;
    logic            branch;
    logic            jump;
    logic [1:0]      wb_sel;
    logic            illegal;
  } id_ex_t;

  // alt selects SUB over ADD and SRA over SRL (funct7[5]).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic            wen;
  logic            ill;
  id_ex_t          d;
  id_ex_t          r;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};

  always_comb begin
    d          = '0;
    wen        = 1'b0;
    ill        = 1'b0;
    d.valid    = 1'b1;
    d.pc       = pc_i;
    d.rs1_data = rs1_data_i;
    d.rs2_data = rs2_data_i;
    d.rd_addr  = rd;
    d.funct3   = funct3;
    d.alu_op   = ALU_ADD;
    d.operand1 = rs1_data_i;
    d.operand2 = rs2_data_i;

    case (opcode)
      OPC_OP: begin
        wen = 1'b1;
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          d.alu_op = alu_from_f3(funct3, funct7[5]);
        else
          ill = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift encodings constrain the upper immediate bits.
        wen        = 1'b1;
        d.operand2 = imm_i;
        d.alu_op   = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))
          ill = 1'b1;
      end
      OPC_LUI: begin
        wen        = 1'b1;
        d.alu_op   = ALU_LUI;
        d.operand1 = '0;
        d.operand2 = imm_u;
      end
      OPC_AUIPC: begin
        wen        = 1'b1;
        d.operand1 = pc_i;
        d.operand2 = imm_u;
      end
      OPC_LOAD: begin
        wen        = 1'b1;
        d.operand2 = imm_i;
        d.mem_rd   = 1'b1;
        d.wb_sel   = 2'd1;
        ill        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d.operand2 = imm_s;
        d.mem_wr   = 1'b1;
        ill        = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        d.operand1 = pc_i;
        d.operand2 = imm_b;
        d.branch   = 1'b1;
        ill        = (funct3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        wen        = 1'b1;
        d.operand1 = pc_i;
        d.operand2 = imm_j;
        d.jump     = 1'b1;
        d.wb_sel   = 2'd2;
      end
      OPC_JALR: begin
        wen        = 1'b1;
        d.operand2 = imm_i;
        d.jump     = 1'b1;
        d.wb_sel   = 2'd2;
        ill        = (funct3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase

    d.illegal = ill;
    // An illegal entry still travels down the pipe, but with no side effects.
    if (ill) begin
      d.rd_wen = 1'b0;
      d.mem_rd = 1'b0;
      d.mem_wr = 1'b0;
      d.branch = 1'b0;
      d.jump   = 1'b0;
      d.wb_sel = 2'd0;
    end else begin
      d.rd_wen = wen && (rd != 5'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i)
      r <= '0;
    else if (stall_i)
      r <= r;
    else if (!valid_i)
      r <= '0;
    else
      r <= d;
  end

  assign valid_o    = r.valid;
  assign pc_o       = r.pc;
  assign alu_op_o   = r.alu_op;
  assign operand1_o = r.operand1;
  assign operand2_o = r.operand2;
  assign rs1_data_o = r.rs1_data;
  assign rs2_data_o = r.rs2_data;
  assign rd_addr_o  = r.rd_addr;
  assign rd_wen_o   = r.rd_wen;
  assign mem_rd_o   = r.mem_rd;
  assign mem_wr_o   = r.mem_wr;
  assign funct3_o   = r.funct3;
  assign branch_o   = r.branch;
  assign jump_o     = r.jump;
  assign wb_sel_o   = r.wb_sel;
  assign illegal_o  = r.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
module tb_id_ex_decode;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] pc_i, instr_i, rs1_data_i, rs2_data_i;
  logic        valid_o;
  logic [31:0] pc_o, operand1_o, operand2_o, rs1_data_o, rs2_data_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o, mem_rd_o, mem_wr_o, branch_o, jump_o, illegal_o;
  logic [2:0]  funct3_o;
  logic [1:0]  wb_sel_o;

  int checks = 0;
  int errors = 0;

  id_ex_decode #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .valid_o(valid_o), .pc_o(pc_o), .alu_op_o(alu_op_o),
    .operand1_o(operand1_o), .operand2_o(operand2_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .funct3_o(funct3_o), .branch_o(branch_o),
    .jump_o(jump_o), .wb_sel_o(wb_sel_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected ID/EX entry; care=0 means ALU op, operands and wb_sel are not defined.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  f3;
    logic        branch;
    logic        jump;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic        care;
  } out_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic        valid;
    logic        e_valid;
    logic [3:0]  e_alu;
    logic [31:0] e_op1, e_op2;
    logic [4:0]  e_rd;
    logic        e_wen, e_mrd, e_mwr, e_br, e_jmp;
    logic [1:0]  e_wb;
    logic        e_ill;
    logic [2:0]  e_f3;
    logic        care;
  } vec_t;

  out_t model;

  function automatic out_t bubble();
    out_t o;
    o      = '0;
    o.care = 1'b1;
    return o;
  endfunction

  // Reference decode, built from the field rules with plain arithmetic.
  function automatic out_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    out_t        o;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii, is, ib, ij, iu;
    logic        legal, writes;
    int          arith_code [8];
    arith_code = '{0, 2, 3, 4, 5, 6, 8, 9};
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    ii  = $unsigned($signed(instr) >>> 20);
    is  = (ii & 32'hFFFF_FFE0) | {27'd0, instr[11:7]};
    ib  = 32'(int'(instr[11:8]) * 2 + int'(instr[30:25]) * 32 + int'(instr[7]) * 2048
              - int'(instr[31]) * 4096);
    ij  = 32'(int'(instr[30:21]) * 2 + int'(instr[20]) * 2048 + int'(instr[19:12]) * 4096
              - int'(instr[31]) * 1048576);
    iu  = {instr[31:12], 12'h000};

    o        = '0;
    o.valid  = 1'b1;
    o.pc     = pc;
    o.rs1d   = rs1;
    o.rs2d   = rs2;
    o.rd     = instr[11:7];
    o.f3     = f3;
    o.op1    = rs1;
    o.op2    = rs2;
    legal    = 1'b1;
    writes   = 1'b1;
    case (opc)
      7'h33: begin
        legal    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        o.alu_op = 4'(arith_code[f3] + ((f7 == 7'h20) ? 1 : 0));
      end
      7'h13: begin
        legal    = !(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
        o.alu_op = 4'(arith_code[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 1 : 0));
        o.op2    = ii;
      end
      7'h37: begin o.alu_op = 4'd10; o.op1 = 32'd0; o.op2 = iu; end
      7'h17: begin o.op1 = pc; o.op2 = iu; end
      7'h03: begin
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        o.op2 = ii; o.mem_rd = 1'b1; o.wb_sel = 2'd1;
      end
      7'h23: begin
        legal = (f3 <= 3'd2); writes = 1'b0;
        o.op2 = is; o.mem_wr = 1'b1;
      end
      7'h63: begin
        legal = !(f3 == 3'd2 || f3 == 3'd3); writes = 1'b0;
        o.op1 = pc; o.op2 = ib; o.branch = 1'b1;
      end
      7'h6F: begin o.op1 = pc; o.op2 = ij; o.jump = 1'b1; o.wb_sel = 2'd2; end
      7'h67: begin
        legal = (f3 == 3'd0);
        o.op2 = ii; o.jump = 1'b1; o.wb_sel = 2'd2;
      end
      default: legal = 1'b0;
    endcase
    o.rd_wen = legal && writes && (instr[11:7] != 5'd0);
    o.care   = legal;
    if (!legal) begin
      o.illegal = 1'b1;
      o.mem_rd  = 1'b0;
      o.mem_wr  = 1'b0;
      o.branch  = 1'b0;
      o.jump    = 1'b0;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input out_t e);
    chk("valid_o",    32'(valid_o),    32'(e.valid));
    chk("pc_o",       pc_o,            e.pc);
    chk("rs1_data_o", rs1_data_o,      e.rs1d);
    chk("rs2_data_o", rs2_data_o,      e.rs2d);
    chk("rd_addr_o",  32'(rd_addr_o),  32'(e.rd));
    chk("rd_wen_o",   32'(rd_wen_o),   32'(e.rd_wen));
    chk("mem_rd_o",   32'(mem_rd_o),   32'(e.mem_rd));
    chk("mem_wr_o",   32'(mem_wr_o),   32'(e.mem_wr));
    chk("funct3_o",   32'(funct3_o),   32'(e.f3));
    chk("branch_o",   32'(branch_o),   32'(e.branch));
    chk("jump_o",     32'(jump_o),     32'(e.jump));
    chk("illegal_o",  32'(illegal_o),  32'(e.illegal));
    if (e.care) begin
      chk("alu_op_o",   32'(alu_op_o), 32'(e.alu_op));
      chk("operand1_o", operand1_o,    e.op1);
      chk("operand2_o", operand2_o,    e.op2);
      chk("wb_sel_o",   32'(wb_sel_o), 32'(e.wb_sel));
    end
  endtask

  // Apply one cycle of inputs, advance the reference pipeline register, compare.
  task automatic drive(input logic r, input logic f, input logic s, input logic v,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    rst_i = r; flush_i = f; stall_i = s; valid_i = v;
    pc_i = pc; instr_i = instr; rs1_data_i = rs1; rs2_data_i = rs2;
    @(posedge clk_i);
    if (r || f)      model = bubble();
    else if (s)      model = model;
    else if (!v)     model = bubble();
    else             model = ref_decode(instr, pc, rs1, rs2);
    #1;
    check_all(model);
  endtask

  vec_t vecs [11];
  logic [6:0] opcs [10];

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    pc_i = '0; instr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    model = bubble();

    // instr, pc, rs1, rs2, valid | valid alu op1 op2 rd wen mrd mwr br jmp wb ill f3 care
    vecs[0]  = '{32'h002081B3, 32'h1000, 32'd5, 32'd7, 1'b1,
                 1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[1]  = '{32'h402081B3, 32'h1004, 32'd5, 32'd7, 1'b1,
                 1'b1, 4'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[2]  = '{32'h40335293, 32'h1008, 32'h8000_0000, 32'd0, 1'b1,
                 1'b1, 4'd7, 32'h8000_0000, 32'h0000_0403, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd5, 1'b1};
    vecs[3]  = '{32'hABCDE0B7, 32'h100C, 32'h1234, 32'd0, 1'b1,
                 1'b1, 4'd10, 32'd0, 32'hABCD_E000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd6, 1'b1};
    vecs[4]  = '{32'h00208033, 32'h1010, 32'd5, 32'd7, 1'b1,
                 1'b1, 4'd0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[5]  = '{32'hFE20AE23, 32'h1014, 32'h100, 32'h55, 1'b1,
                 1'b1, 4'd0, 32'h100, 32'hFFFF_FFFC, 5'd28, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd2, 1'b1};
    vecs[6]  = '{32'h00812203, 32'h1018, 32'h200, 32'd0, 1'b1,
                 1'b1, 4'd0, 32'h200, 32'd8, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd2, 1'b1};
    vecs[7]  = '{32'h00208863, 32'h1000, 32'd1, 32'd2, 1'b1,
                 1'b1, 4'd0, 32'h1000, 32'd16, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
    vecs[8]  = '{32'h008000EF, 32'h2000, 32'd1, 32'd2, 1'b1,
                 1'b1, 4'd0, 32'h2000, 32'd8, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0, 1'b1};
    vecs[9]  = '{32'h00000000, 32'h2004, 32'd9, 32'd9, 1'b1,
                 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 1'b0};
    vecs[10] = '{32'h00000000, 32'h2008, 32'd9, 32'd9, 1'b0,
                 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h002081B3, 32'd1, 32'd2);

    // Directed vectors against hand-derived values
    foreach (vecs[i]) begin
      drive(1'b0, 1'b0, 1'b0, vecs[i].valid, vecs[i].pc, vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
      chk("vec_valid",   32'(valid_o),   32'(vecs[i].e_valid));
      chk("vec_rd",      32'(rd_addr_o), 32'(vecs[i].e_rd));
      chk("vec_rd_wen",  32'(rd_wen_o),  32'(vecs[i].e_wen));
      chk("vec_mem_rd",  32'(mem_rd_o),  32'(vecs[i].e_mrd));
      chk("vec_mem_wr",  32'(mem_wr_o),  32'(vecs[i].e_mwr));
      chk("vec_branch",  32'(branch_o),  32'(vecs[i].e_br));
      chk("vec_jump",    32'(jump_o),    32'(vecs[i].e_jmp));
      chk("vec_illegal", 32'(illegal_o), 32'(vecs[i].e_ill));
      chk("vec_funct3",  32'(funct3_o),  32'(vecs[i].e_f3));
      chk("vec_pc",      pc_o,           vecs[i].valid ? vecs[i].pc  : 32'd0);
      chk("vec_rs2",     rs2_data_o,     vecs[i].valid ? vecs[i].rs2 : 32'd0);
      if (vecs[i].care) begin
        chk("vec_alu_op", 32'(alu_op_o), 32'(vecs[i].e_alu));
        chk("vec_op1",    operand1_o,    vecs[i].e_op1);
        chk("vec_op2",    operand2_o,    vecs[i].e_op2);
        chk("vec_wb_sel", 32'(wb_sel_o), 32'(vecs[i].e_wb));
      end
    end

    // Stall holds the entry while the input instruction changes
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 32'h002081B3, 32'd5, 32'd7);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h3100 + 32'(k), 32'hFE20AE23, 32'h100, 32'h55);
      chk("stall_alu_op", 32'(alu_op_o), 32'd0);
      chk("stall_op1",    operand1_o,    32'd5);
      chk("stall_pc",     pc_o,          32'h3000);
      chk("stall_mem_wr", 32'(mem_wr_o), 32'd0);
    end
    // Flush beats stall
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h3200, 32'hFE20AE23, 32'h100, 32'h55);
    chk("flush_valid",  32'(valid_o),  32'd0);
    chk("flush_rd_wen", 32'(rd_wen_o), 32'd0);
    chk("flush_mem_wr", 32'(mem_wr_o), 32'd0);
    // Reset mid-stream
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3300, 32'h00812203, 32'h200, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h3304, 32'h002081B3, 32'd5, 32'd7);
    chk("rst_valid",  32'(valid_o),  32'd0);
    chk("rst_mem_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_op2",    operand2_o,    32'd0);
    // Stall over an invalid input keeps the loaded entry
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3400, 32'h008000EF, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h3404, 32'h00000000, 32'd0, 32'd0);
    chk("stall_bubble_jump", 32'(jump_o), 32'd1);

    // Randomized traffic against the reference model
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h00};
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      logic        r, f, s, v;
      ins      = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0:       ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        default: ins[31:25] = ins[31:25];
      endcase
      if ($urandom_range(0, 19) == 0) ins[6:0] = 7'($urandom);
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 7) != 0);
      drive(r, f, s, v, $urandom, ins, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
